// File: rtl/spi_s_mode_slave_pkg.sv
// Shared types and default constants for the SPI mode-selectable slave.
// Imported by the synchronizer and the top-level slave.
package spi_s_pkg_hdl;

   localparam int DEF_DATA_W    = 8;
   localparam bit DEF_MSB_FIRST = 1'b1;

   // Cycles after reset before the synchronized cs_n reflects the pin.
   localparam int SYNC_FLUSH    = 2;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } spi_s_state_t;

endpackage

// File: rtl/spi_s_sync.sv
// Two-flop synchronizer for one asynchronous input.
// RST_VAL selects the level the flops hold during reset.
module spi_s_sync
   import spi_s_pkg_hdl::*;
#(
   parameter logic RST_VAL = 1'b0
)(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both flops
   // update from pre-edge values and form a true two-stage chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_s_mode_slave.sv
// SPI slave supporting all four CPOL/CPHA modes, oversampled on clk,
// with a one-entry TX shadow, an RX holding register and sticky error flags.
module spi_s_mode_slave
   import spi_s_pkg_hdl::*;
#(
   parameter int                DATA_W       = DEF_DATA_W,
   parameter bit                MSB_FIRST    = DEF_MSB_FIRST,
   parameter logic [DATA_W-1:0] IDLE_PATTERN = '1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              ovr,
   output logic              udr,
   output logic              abort,
   input  logic              flag_clr
);

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sclk_s, cs_n_s, mosi_s;
   logic sclk_d, cs_n_d;
   logic [1:0] flush_cnt;
   logic armed;

   spi_s_state_t state, next_state;
   logic enter, leave;
   spi_mode_t mode_q;

   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_sh, rx_next;
   logic [DATA_W-1:0] tx_sh, shadow, load_word;
   logic shadow_full, word_done, miso_q;

   logic sclk_rise, sclk_fall, lead, trail, cs_fall, cs_rise;
   logic active, sample_evt, shift_evt, load_evt, load_cpha;

   function automatic logic head_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   spi_s_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
   spi_s_sync #(.RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .d(cs_n), .q(cs_n_s));
   spi_s_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

   // armed blocks a frame entry until cs_n has been seen high after reset,
   // so a master still holding cs_n low across reset is not re-joined mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_d    <= 1'b0;
         cs_n_d    <= 1'b1;
         flush_cnt <= '0;
         armed     <= 1'b0;
      end else begin
         sclk_d <= sclk_s;
         cs_n_d <= cs_n_s;
         if (flush_cnt != 2'(SYNC_FLUSH))
            flush_cnt <= flush_cnt + 2'd1;
         if (flush_cnt == 2'(SYNC_FLUSH) && cs_n_s)
            armed <= 1'b1;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = armed & cs_n_d & ~cs_n_s;
   assign cs_rise   = ~cs_n_d & cs_n_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      enter      = 1'b0;
      leave      = 1'b0;
      case (state)
         S_IDLE: begin
            if (cs_fall) begin
               next_state = S_ACTIVE;
               enter      = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (cs_rise) begin
               next_state = S_IDLE;
               leave      = 1'b1;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign lead  = mode_q.cpol ? sclk_fall : sclk_rise;
   assign trail = mode_q.cpol ? sclk_rise : sclk_fall;

   // In CPHA=0 the trailing edge right after a word wrap must not shift:
   // the next word's first bit was already placed on miso by the reload.
   assign active     = (state == S_ACTIVE) & ~cs_rise;
   assign sample_evt = active & (mode_q.cpha ? trail : lead);
   assign shift_evt  = active & (mode_q.cpha ? lead : (trail & (bit_cnt != '0)));
   assign load_evt   = enter | (active & word_done);
   assign load_cpha  = enter ? cpha : mode_q.cpha;
   assign load_word  = shadow_full ? shadow : IDLE_PATTERN;

   assign rx_next = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_s}
                              : {mosi_s, rx_sh[DATA_W-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= '0;
         bit_cnt   <= '0;
         rx_sh     <= '0;
         word_done <= 1'b0;
         abort     <= 1'b0;
      end else begin
         word_done <= 1'b0;
         abort     <= 1'b0;
         if (enter) begin
            mode_q  <= spi_mode_t'{cpol: cpol, cpha: cpha};
            bit_cnt <= '0;
         end else if (leave) begin
            abort   <= (bit_cnt != '0);
            bit_cnt <= '0;
         end else if (sample_evt) begin
            rx_sh     <= rx_next;
            word_done <= (bit_cnt == LAST_BIT);
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
         end
      end
   end

   // TX path: the shadow is consumed only at a word start, and a push is only
   // accepted while empty, so the two never collide on shadow_full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sh       <= '0;
         shadow      <= '0;
         shadow_full <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         if (load_evt) begin
            if (!load_cpha) begin
               miso_q <= head_bit(load_word);
               tx_sh  <= drop_bit(load_word);
            end else begin
               tx_sh  <= load_word;
            end
         end else if (shift_evt) begin
            miso_q <= head_bit(tx_sh);
            tx_sh  <= drop_bit(tx_sh);
         end

         if (load_evt && shadow_full) begin
            shadow_full <= 1'b0;
         end else if (tx_valid && tx_ready) begin
            shadow      <= tx_data;
            shadow_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         ovr      <= 1'b0;
         udr      <= 1'b0;
      end else begin
         if (word_done) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         // A set event outranks a simultaneous clear.
         if (word_done && rx_valid && !rx_ready) ovr <= 1'b1;
         else if (flag_clr)                      ovr <= 1'b0;

         if (load_evt && !shadow_full) udr <= 1'b1;
         else if (flag_clr)            udr <= 1'b0;
      end
   end

   assign tx_ready = ~shadow_full & ~rst;
   assign miso_oe  = (state == S_ACTIVE);
   assign miso     = miso_oe & miso_q;

endmodule

// File: tb/tb_spi_s_mode_slave.sv
// Directed bench for spi_s_mode_slave: a bit-banged SPI master walks through
// all four modes, back-to-back words, underrun, overrun, abort and mid-frame reset.
module tb_spi_s_mode_slave;

   localparam int W    = 8;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst, sclk, cs_n, mosi, cpol, cpha;
   logic miso, miso_oe;
   logic [W-1:0] tx_data, rx_data;
   logic tx_valid, tx_ready, rx_valid, rx_ready;
   logic ovr, udr, abort, flag_clr;

   int n_vec     = 0;
   int n_err     = 0;
   int abort_cnt = 0;
   int a0;
   logic [W-1:0] got;

   always #5 clk = ~clk;

   // Counts clk cycles during which abort is high.
   always @(posedge clk) if (abort) abort_cnt <= abort_cnt + 1;

   spi_s_mode_slave dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .ovr(ovr), .udr(udr), .abort(abort), .flag_clr(flag_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input logic [W-1:0] d);
      int t = 0;
      while (!tx_ready && t < 20) begin
         cyc(1);
         t++;
      end
      check("push_ready", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
   endtask

   task automatic ack_rx();
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
   endtask

   task automatic frame_begin(input logic pol, input logic pha);
      cpol = pol;
      cpha = pha;
      sclk = pol;
      cyc(HALF);
      cs_n = 1'b0;
      cyc(HALF);
   endtask

   task automatic frame_end();
      cyc(HALF);
      cs_n = 1'b1;
      cyc(HALF);
   endtask

   // Master side, MSB first; miso is captured on the master's sample edge.
   task automatic xfer(input logic [W-1:0] d, input int nbits, output logic [W-1:0] q);
      q = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = d[W-1-i];
            cyc(HALF);
            sclk = ~cpol;
            q[W-1-i] = miso;
            cyc(HALF);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = d[W-1-i];
            cyc(HALF);
            sclk = cpol;
            q[W-1-i] = miso;
            cyc(HALF);
         end
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b0; tx_data = '0;
      rx_ready = 1'b0; flag_clr = 1'b0;
      cyc(3);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_miso", miso, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_flags", {ovr, udr, abort}, 0);
      rst = 1'b0;
      cyc(2);
      check("post_rst_tx_ready", tx_ready, 1);
      cyc(5);

      // Mode 0, tx 0x3C preloaded, master sends 0xA5.
      push_tx(8'h3C);
      check("m0_shadow_full", tx_ready, 0);
      frame_begin(1'b0, 1'b0);
      check("m0_oe", miso_oe, 1);
      xfer(8'hA5, 8, got);
      check("m0_miso", got, 8'h3C);
      check("m0_rx_valid", rx_valid, 1);
      check("m0_rx_data", rx_data, 8'hA5);
      frame_end();
      // The word start after the last bit finds the shadow empty.
      check("m0_udr_tail", udr, 1);
      check("m0_oe_idle", miso_oe, 0);
      check("m0_miso_idle", miso, 0);
      ack_rx();
      check("m0_rx_ack", rx_valid, 0);
      pulse_clr();
      check("m0_udr_clr", udr, 0);

      // Mode 3, back-to-back 0x12, 0x34; tx 0x55, 0xAA, then a filler word.
      push_tx(8'h55);
      frame_begin(1'b1, 1'b1);
      push_tx(8'hAA);
      xfer(8'h12, 8, got);
      check("m3_miso0", got, 8'h55);
      check("m3_rx_valid0", rx_valid, 1);
      check("m3_rx_data0", rx_data, 8'h12);
      ack_rx();
      push_tx(8'h00);
      xfer(8'h34, 8, got);
      check("m3_miso1", got, 8'hAA);
      check("m3_rx_valid1", rx_valid, 1);
      check("m3_rx_data1", rx_data, 8'h34);
      frame_end();
      check("m3_udr", udr, 0);
      check("m3_ovr", ovr, 0);
      ack_rx();

      // Mode 1, no tx word: idle pattern and underrun.
      frame_begin(1'b0, 1'b1);
      xfer(8'h5A, 8, got);
      check("m1_miso_idle_pat", got, 8'hFF);
      check("m1_udr", udr, 1);
      check("m1_rx_data", rx_data, 8'h5A);
      frame_end();
      pulse_clr();
      check("m1_udr_clr", udr, 0);
      ack_rx();

      // Mode 2, rx_ready held low across two words.
      frame_begin(1'b1, 1'b0);
      xfer(8'h01, 8, got);
      check("m2_rx_data0", rx_data, 8'h01);
      check("m2_ovr0", ovr, 0);
      xfer(8'h02, 8, got);
      check("m2_rx_data1", rx_data, 8'h02);
      check("m2_ovr1", ovr, 1);
      check("m2_rx_valid", rx_valid, 1);
      frame_end();
      pulse_clr();
      check("m2_ovr_clr", ovr, 0);
      ack_rx();

      // Truncated frame after 5 bits, then a clean word.
      a0 = abort_cnt;
      frame_begin(1'b0, 1'b0);
      xfer(8'hFF, 5, got);
      frame_end();
      check("abort_pulse_cycles", 32'(abort_cnt - a0), 1);
      check("abort_no_rx", rx_valid, 0);
      frame_begin(1'b0, 1'b0);
      xfer(8'hC3, 8, got);
      frame_end();
      check("after_abort_rx_data", rx_data, 8'hC3);
      check("after_abort_rx_valid", rx_valid, 1);

      // Reset after 3 bits with cs_n held low through reset release.
      a0 = abort_cnt;
      frame_begin(1'b0, 1'b0);
      xfer(8'hFF, 3, got);
      rst = 1'b1;
      cyc(2);
      check("mid_rst_rx_valid", rx_valid, 0);
      check("mid_rst_rx_data", rx_data, 0);
      check("mid_rst_oe", {miso_oe, miso}, 0);
      check("mid_rst_flags", {ovr, udr, abort}, 0);
      check("mid_rst_tx_ready", tx_ready, 0);
      rst = 1'b0;
      cyc(12);
      check("no_reentry_oe", miso_oe, 0);
      cs_n = 1'b1;
      cyc(HALF);
      frame_begin(1'b0, 1'b0);
      xfer(8'h7E, 8, got);
      frame_end();
      check("after_rst_rx_data", rx_data, 8'h7E);
      check("after_rst_rx_valid", rx_valid, 1);
      check("after_rst_no_abort", 32'(abort_cnt - a0), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_s_mode_slave.md
SPI_S_MODE_SLAVE -- requirements
Module: spi_s_mode_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word length in bits (legal 4..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning shift order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have parameter IDLE_PATTERN, default all-ones DATA_W, meaning word shifted out on TX underrun.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: sclk  in  1  SPI serial clock, asynchronous to clk.
REQ-007 SHALL have ports: cs_n  in  1  SPI chip select, active low, asynchronous.
REQ-008 SHALL have ports: mosi  in  1  SPI master-out data, asynchronous.
REQ-009 SHALL have ports: miso  out  1  SPI slave-out data; miso_oe  out  1  MISO output enable.
REQ-010 SHALL have ports: cpol  in  1; cpha  in  1  SPI mode select.
REQ-011 SHALL have ports: tx_data  in  DATA_W; tx_valid  in  1; tx_ready  out  1  TX word handshake.
REQ-012 SHALL have ports: rx_data  out  DATA_W; rx_valid  out  1; rx_ready  in  1  RX word handshake.
REQ-013 SHALL have ports: ovr  out  1  sticky RX overrun; udr  out  1  sticky TX underrun; abort  out  1  one-cycle pulse on truncated frame; flag_clr  in  1  clears ovr and udr.

Function
REQ-014 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers; an edge is detected from the synchronized sclk, so an SPI event is acted on 3 clk cycles after the pin transition; sclk frequency SHALL be at most clk/8.
REQ-015 SHALL implement states IDLE and ACTIVE; IDLE -> ACTIVE on synchronized cs_n falling; ACTIVE -> IDLE on synchronized cs_n rising.
REQ-016 SHALL latch cpol/cpha on the IDLE -> ACTIVE transition; changes while ACTIVE SHALL be ignored.
REQ-017 SHALL treat the leading edge as the transition away from the latched cpol level; CPHA=0: sample mosi on leading, shift miso on trailing; CPHA=1: shift miso on leading, sample mosi on trailing.
REQ-018 SHALL hold a one-entry TX shadow register; tx_ready = shadow empty; the shadow loads when tx_valid and tx_ready are both high.
REQ-019 SHALL load the TX shift register at each word start (ACTIVE entry, and the cycle after the last-bit sample while cs_n stays low) from the shadow if full (emptying it), else from IDLE_PATTERN with udr set.
REQ-020 SHALL, for CPHA=0, drive the first bit on miso at ACTIVE entry; for CPHA=1, drive it on the first leading edge.
REQ-021 SHALL keep a bit counter 0..DATA_W-1, wrapping to 0 after the sample of bit DATA_W-1; back-to-back words SHALL need no cs_n toggle.
REQ-022 SHALL, one clk after the sample of bit DATA_W-1, write the RX word into an RX holding register and raise rx_valid; rx_valid stays high until rx_valid and rx_ready are both high.
REQ-023 SHALL, if a new word completes while rx_valid is high, overwrite rx_data, keep rx_valid high and set ovr.
REQ-024 SHALL, on cs_n rising with bit counter nonzero, discard the partial word, pulse abort for one cycle and return the counter to 0; a TX shadow word loaded into the shifter is consumed.
REQ-025 SHALL drive miso_oe = 1 only in ACTIVE; miso = 0 when miso_oe = 0.
REQ-026 SHALL clear ovr and udr on flag_clr; a set event in the same cycle as flag_clr SHALL win.

Reset
REQ-027 SHALL, on rst, asynchronously force state IDLE, counter 0, shifters 0, shadow empty, tx_ready 0 while rst is high and 1 the first cycle after, rx_valid 0, rx_data 0, miso 0, miso_oe 0, ovr 0, udr 0, abort 0, synchronizer flops to idle levels (cs_n 1, sclk 0).
REQ-028 SHALL, on reset mid-frame, drop the frame with no abort pulse, and re-enter ACTIVE only on a fresh synchronized cs_n falling edge.

Structure
REQ-029 SHALL place spi_mode_t (2-bit {cpol,cpha}), the state enum spi_s_state_t and the default constants in spi_s_pkg_hdl.
REQ-030 SHALL instantiate one sub-module, spi_s_sync (2-flop synchronizer with reset value parameter), once per asynchronous input.

Verification
REQ-031 Mode 0, DATA_W=8, master sends 0xA5, tx_data=0x3C preloaded -> rx_data=0xA5 with rx_valid; miso bits 0,0,1,1,1,1,0,0.
REQ-032 Mode 3, two back-to-back words 0x12, 0x34 in one cs_n frame, tx 0x55 then 0xAA -> two rx_valid events 0x12, 0x34; miso 0x55 then 0xAA; udr=0.
REQ-033 Mode 1, no tx_valid -> miso shifts 0xFF, udr=1; flag_clr -> udr=0.
REQ-034 Mode 2, rx_ready held 0 across words 0x01, 0x02 -> rx_data=0x02, ovr=1, rx_valid stays 1.
REQ-035 cs_n deasserted after 5 bits -> abort one-cycle pulse, no rx_valid, next frame word 0xC3 received correctly.
REQ-036 rst asserted after bit 3 -> all outputs at reset values; next frame 0x7E received correctly.
